// File: rtl/sinc3_pkg.sv
// Shared definitions for the sinc3 decimation controller.
//   DATA_W / GAIN_FRAC : sample width and gain fraction bits (Q1.15 gain).
//   PROD_W             : width of the signed offset-corrected product.
//   sat_u16()          : clamp a signed product to the unsigned 16-bit range.
//   dec_rate_legal()   : true for power-of-two decimation rates in 32..4096.
package sinc3_pkg;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned GAIN_FRAC    = 15;
    localparam int unsigned PROD_W       = 35;
    localparam int unsigned DEC_RATE_MIN = 32;
    localparam int unsigned DEC_RATE_MAX = 4096;

    function automatic logic [DATA_W-1:0] sat_u16(input logic signed [PROD_W-1:0] r);
        logic [DATA_W-1:0] res;
        if (r < 0) begin
            res = '0;
        end else if (r > 35'sd65535) begin
            res = '1;
        end else begin
            res = r[DATA_W-1:0];
        end
        return res;
    endfunction

    function automatic bit dec_rate_legal(input int unsigned rate);
        return (rate >= DEC_RATE_MIN) && (rate <= DEC_RATE_MAX) && ((rate & (rate - 1)) == 0);
    endfunction

endpackage

// File: rtl/sinc3_decim_ctrl_if.sv
// Corrected-sample stream toward the downstream consumer.
//   out_data  : head word of the output buffer (holds its last value when empty)
//   out_valid : buffer not empty
//   out_ready : consumer accepts; a word is popped when out_valid && out_ready
// master = producer (the controller), slave = consumer.
interface sinc3_decim_ctrl_if;
    import sinc3_pkg::*;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sinc3_decim_fifo.sv
// Small synchronous FIFO with a registered head word.
//   clk_i, rst_i    : clock and synchronous active-high reset
//   push_i, wdata_i : write request and data (ignored when full without a pop)
//   pop_i           : read request (ignored when empty)
//   full_o, empty_o : occupancy flags
//   head_o          : registered oldest word; holds its last value when empty
module sinc3_decim_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    count_after_pop;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);

        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;

        count_after_pop = do_pop ? count_q - CW'(1) : count_q;
        count_d         = do_push ? count_after_pop + CW'(1) : count_after_pop;

        // The head is either the word being written into an (effectively) empty
        // buffer, or the already-stored word at the new read pointer.
        head_d = head_q;
        if (do_push && (count_after_pop == '0)) begin
            head_d = wdata_i;
        end else if (count_after_pop != '0) begin
            head_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sinc3_decim_ctrl.sv
// Decimation timing, capture, settling, offset/gain correction and output
// buffering for a sinc3 decimation filter.
//   mclkin, rst       : modulator clock and synchronous active-high reset
//   run_i             : enable; low stops the divider and clears settling
//   word_clk_o        : registered decimated clock to the filter (50% duty)
//   data_in_i         : unsigned filter output, sampled CAPTURE_DLY cycles into a period
//   offset_i, gain_i  : signed offset and unsigned Q1.15 gain, sampled with the data
//   ovf_o, ovf_clr_i  : sticky drop flag and its clear pulse
//   settled_o         : high once the filter's settling words have been discarded
//   ovf_cnt_o         : saturating drop count (only with SINC3_DECIM_OVF_CNT_EN)
//   out_if            : corrected-sample stream (master side)
// Optional feature macro: SINC3_DECIM_OVF_CNT_EN.
module sinc3_decim_ctrl
    import sinc3_pkg::*;
#(
    parameter int unsigned DEC_RATE     = 256,
    parameter int unsigned CAPTURE_DLY  = 2,
    parameter int unsigned SETTLE_WORDS = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              mclkin,
    input  logic              rst,
    input  logic              run_i,
    output logic              word_clk_o,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [DATA_W-1:0] offset_i,
    input  logic [DATA_W-1:0] gain_i,
    output logic              ovf_o,
    input  logic              ovf_clr_i,
    output logic              settled_o,
`ifdef SINC3_DECIM_OVF_CNT_EN
    output logic [7:0]        ovf_cnt_o,
`endif
    sinc3_decim_ctrl_if.master out_if
);

    localparam int unsigned CNT_W = $clog2(DEC_RATE);
    localparam int unsigned SET_W = (SETTLE_WORDS > 0) ? $clog2(SETTLE_WORDS + 1) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DEC_RATE / 2);
    localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(CAPTURE_DLY);
    localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SETTLE_WORDS);

    if (!dec_rate_legal(DEC_RATE)) begin : g_bad_dec_rate
        $error("DEC_RATE must be a power of two in 32..4096");
    end

    // Divider and settling
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             word_clk_q, word_clk_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             settled_q, settled_d;
    logic             strobe, keep;

    // Correction pipeline
    logic signed [17:0]       diff;
    logic signed [PROD_W-1:0] diff_x, gain_x;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]        word_q, word_d;
    logic                     push_q, push_d;

    // Output buffer and overflow
    logic              fifo_full, fifo_empty, fifo_push, pop, drop;
    logic [DATA_W-1:0] fifo_head;
    logic              ovf_q, ovf_d;

    always_comb begin
        strobe = run_i && (cnt_q == CAP_CNT);
        keep   = strobe && (settle_q == SET_MAX);

        // Counter stops at zero while idle so the next run starts a fresh period.
        cnt_d      = run_i ? cnt_q + CNT_W'(1) : '0;
        word_clk_d = run_i && (cnt_q < HALF_CNT);

        settle_d = settle_q;
        if (!run_i) begin
            settle_d = '0;
        end else if (strobe && (settle_q != SET_MAX)) begin
            settle_d = settle_q + SET_W'(1);
        end
        settled_d = run_i && (settle_d == SET_MAX);

        // Offset first in 18 bits so unsigned data minus a negative offset cannot wrap.
        diff   = $signed({2'b00, data_in_i}) - $signed({{2{offset_i[DATA_W-1]}}, offset_i});
        diff_x = {{(PROD_W - 18){diff[17]}}, diff};
        gain_x = {{(PROD_W - DATA_W){1'b0}}, gain_i};
        prod_d   = keep ? diff_x * gain_x : prod_q;
        s1_vld_d = keep;

        push_d = s1_vld_q;
        word_d = s1_vld_q ? sat_u16(prod_q >>> GAIN_FRAC) : word_q;

        pop       = !fifo_empty && out_if.out_ready;
        // A pop in the same cycle frees the slot, so a full buffer still accepts.
        fifo_push = push_q && (!fifo_full || pop);
        drop      = push_q && fifo_full && !pop;

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge mclkin) begin
        if (rst) begin
            cnt_q      <= '0;
            word_clk_q <= 1'b0;
            settle_q   <= '0;
            settled_q  <= 1'b0;
            prod_q     <= '0;
            s1_vld_q   <= 1'b0;
            word_q     <= '0;
            push_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            word_clk_q <= word_clk_d;
            settle_q   <= settle_d;
            settled_q  <= settled_d;
            prod_q     <= prod_d;
            s1_vld_q   <= s1_vld_d;
            word_q     <= word_d;
            push_q     <= push_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef SINC3_DECIM_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop) begin
            // A clear coinciding with a drop still counts that drop.
            if (ovf_clr_i) begin
                ovf_cnt_d = 8'd1;
            end else if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
        end else if (ovf_clr_i) begin
            ovf_cnt_d = '0;
        end
    end

    always_ff @(posedge mclkin) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`endif

    sinc3_decim_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i   (mclkin),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .wdata_i (word_q),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign word_clk_o       = word_clk_q;
    assign settled_o        = settled_q;
    assign ovf_o            = ovf_q;
    assign out_if.out_data  = fifo_head;
    assign out_if.out_valid = !fifo_empty;

endmodule

// File: tb/tb_sinc3_decim_ctrl.sv
// Randomized scoreboard bench for sinc3_decim_ctrl (DEC_RATE=32).
module tb_sinc3_decim_ctrl;

    localparam int unsigned DEC    = 32;
    localparam int unsigned CAP    = 2;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEPTH  = 4;

    logic        mclkin, rst, run, ovf_clr, out_ready;
    logic [15:0] data_in, offset, gain;
    logic        word_clk, ovf, settled;
`ifdef SINC3_DECIM_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    sinc3_decim_ctrl_if u_if ();
    assign u_if.out_ready = out_ready;

    sinc3_decim_ctrl #(
        .DEC_RATE     (DEC),
        .CAPTURE_DLY  (CAP),
        .SETTLE_WORDS (SETTLE),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .mclkin     (mclkin),
        .rst        (rst),
        .run_i      (run),
        .word_clk_o (word_clk),
        .data_in_i  (data_in),
        .offset_i   (offset),
        .gain_i     (gain),
        .ovf_o      (ovf),
        .ovf_clr_i  (ovf_clr),
        .settled_o  (settled),
`ifdef SINC3_DECIM_OVF_CNT_EN
        .ovf_cnt_o  (ovf_cnt),
`endif
        .out_if     (u_if)
    );

    initial begin
        mclkin = 1'b0;
        forever #5 mclkin = ~mclkin;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Corrected value straight from the arithmetic definition (floor division by 2^15).
    function automatic logic [15:0] calc_expected(input logic [15:0] d, input logic [15:0] o,
                                                  input logic [15:0] g);
        longint so, dl, p, r;
        so = (o >= 16'h8000) ? longint'(o) - 65536 : longint'(o);
        dl = longint'(d) - so;
        p  = dl * longint'(g);
        if (p >= 0) r = p / 32768;
        else        r = -((-p + 32767) / 32768);
        if (r < 0)     return 16'h0000;
        if (r > 65535) return 16'hFFFF;
        return 16'(r);
    endfunction

    typedef struct {
        logic [15:0] val;
        longint      due;
    } pend_t;

    // Reference model state
    pend_t       pend_q[$];
    logic [15:0] exp_q[$];
    longint      cyc       = 0;
    longint      run_cyc   = 0;
    int          settle_m  = 0;
    int          occ_m     = 0;
    int          strobe_cnt = 0;
    bit          ovf_m = 0, settled_m = 0, wclk_m = 0, in_reset_m = 0, started = 0;
    int          ovf_cnt_m = 0;

    // Predictor: sees the inputs exactly as the DUT samples them at each edge.
    initial begin
        forever begin
            @(posedge mclkin);
            cyc++;
            started = 1;
            if (rst) begin
                pend_q.delete();
                exp_q.delete();
                run_cyc = 0; settle_m = 0; occ_m = 0;
                ovf_m = 0; ovf_cnt_m = 0; settled_m = 0; wclk_m = 0;
                in_reset_m = 1;
            end else begin
                bit pop_m, drop_m, strobe_m;
                pend_t it;
                in_reset_m = 0;
                drop_m = 0;
                pop_m  = (occ_m > 0) && out_ready;
                if (pop_m) occ_m--;
                if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                    it = pend_q.pop_front();
                    if (occ_m < DEPTH) begin
                        occ_m++;
                        exp_q.push_back(it.val);
                    end else begin
                        drop_m = 1;
                    end
                end
                if (drop_m) begin
                    ovf_m     = 1;
                    ovf_cnt_m = ovf_clr ? 1 : ((ovf_cnt_m < 255) ? ovf_cnt_m + 1 : 255);
                end else if (ovf_clr) begin
                    ovf_m     = 0;
                    ovf_cnt_m = 0;
                end
                strobe_m = 0;
                if (run) begin
                    longint phase;
                    phase    = run_cyc % DEC;
                    strobe_m = (phase == CAP);
                    wclk_m   = (phase < DEC / 2);
                    run_cyc++;
                end else begin
                    run_cyc  = 0;
                    wclk_m   = 0;
                    settle_m = 0;
                end
                if (strobe_m) begin
                    strobe_cnt++;
                    if (settle_m < SETTLE) begin
                        settle_m++;
                    end else begin
                        it.val = calc_expected(data_in, offset, gain);
                        it.due = cyc + 2;
                        pend_q.push_back(it);
                    end
                end
                settled_m = run && (settle_m == SETTLE);
            end
        end
    end

    // Monitor: checks status every cycle, pops the scoreboard on each handshake.
    logic [15:0] last_m = 16'h0000;
    initial begin
        forever begin
            @(negedge mclkin);
            if (started) begin
                if (in_reset_m) last_m = 16'h0000;
                check("out_valid", longint'(u_if.out_valid), longint'(occ_m != 0));
                check("word_clk", longint'(word_clk), longint'(wclk_m));
                check("settled", longint'(settled), longint'(settled_m));
                check("ovf", longint'(ovf), longint'(ovf_m));
`ifdef SINC3_DECIM_OVF_CNT_EN
                check("ovf_cnt", longint'(ovf_cnt), longint'(ovf_cnt_m));
`endif
                if (u_if.out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL out_data: got 0x%0h, expected no word at %0t",
                                 u_if.out_data, $time);
                    end else begin
                        check("out_data", longint'(u_if.out_data), longint'(exp_q[0]));
                        if (out_ready) last_m = exp_q.pop_front();
                    end
                end else begin
                    check("out_data_hold", longint'(u_if.out_data), longint'(last_m));
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge mclkin);
        #1;
    endtask

    task automatic wait_strobe();
        int start;
        bit seen;
        start = strobe_cnt;
        seen  = 0;
        for (int c = 0; c < 2 * DEC + 4; c++) begin
            @(posedge mclkin);
            #1;
            if (strobe_cnt != start) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL strobe_timeout: got none, expected one within %0d cycles", 2 * DEC + 4);
        end
    endtask

    task automatic next_word(input logic [15:0] d, input logic [15:0] o, input logic [15:0] g);
        wait_strobe();
        data_in = d;
        offset  = o;
        gain    = g;
    endtask

    logic [15:0] vec_d [7] = '{16'h1234, 16'h1234, 16'hC000, 16'h0010, 16'hFFF8, 16'h0000,
                               16'hFFFF};
    logic [15:0] vec_o [7] = '{16'h0034, 16'h0034, 16'h0000, 16'h0020, 16'hFFF0, 16'h0000,
                               16'h8000};
    logic [15:0] vec_g [7] = '{16'h8000, 16'h4000, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000,
                               16'h8000};

    initial begin
        int last_sc;
        bit stall;
        rst = 1; run = 0; ovf_clr = 0; out_ready = 1;
        data_in = 16'h1000; offset = 16'h0000; gain = 16'h8000;
        repeat (3) @(posedge mclkin);
        #1;
        rst = 0;
        run = 1;

        // Settling and nominal unity-gain words
        repeat (7) next_word(16'h1000, 16'h0000, 16'h8000);

        // Offset, gain and saturation corners
        for (int i = 0; i < 7; i++) next_word(vec_d[i], vec_o[i], vec_g[i]);
        next_word(16'h1000, 16'h0000, 16'h8000);

        // Overflow: six words against a stalled consumer, then drain in order
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            wait_strobe();
            data_in = data_in + 16'h0101;
        end
        wait_cycles(4);
        out_ready = 1;
        wait_cycles(8);
        ovf_clr = 1;
        wait_cycles(1);
        ovf_clr = 0;

        // Full buffer with pop coinciding with the push
        out_ready = 0;
        repeat (4) wait_strobe();
        wait_cycles(4);
        wait_strobe();
        wait_cycles(1);
        out_ready = 1;
        wait_cycles(1);
        out_ready = 0;
        wait_cycles(4);
        out_ready = 1;
        wait_cycles(8);

        // Randomized operation with per-word stalls
        last_sc = strobe_cnt;
        stall   = 0;
        for (int c = 0; c < 24 * DEC; c++) begin
            @(posedge mclkin);
            #1;
            ovf_clr   = ($urandom_range(63) == 0);
            if (strobe_cnt != last_sc) begin
                last_sc = strobe_cnt;
                stall   = ($urandom_range(2) == 0);
                data_in = 16'($urandom);
                offset  = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(255));
                gain    = ($urandom_range(1) == 0) ? 16'($urandom) : 16'h8000;
            end
            out_ready = stall ? 1'b0 : ($urandom_range(3) != 0);
        end
        ovf_clr   = 0;
        out_ready = 1;
        wait_cycles(10);

        // run drop mid-period: buffered words still drain
        out_ready = 0;
        repeat (2) wait_strobe();
        wait_cycles(10);
        run = 0;
        wait_cycles(5);
        out_ready = 1;
        wait_cycles(20);
        run = 1;
        for (int i = 0; i < 6; i++) next_word(16'($urandom), 16'($urandom_range(64)), 16'h6000);
        wait_cycles(10);

        // Reset mid-period with words buffered, then settle again
        out_ready = 0;
        repeat (7) wait_strobe();
        wait_cycles(10);
        rst = 1;
        wait_cycles(1);
        rst = 0;
        wait_cycles(2);
        out_ready = 1;
        repeat (7) wait_strobe();
        wait_cycles(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
